// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch_align instruction fetch/realignment stage.
package fetch_pkg;

   typedef enum logic [0:0] {
      FA_FILL = 1'b0,
      FA_RUN  = 1'b1
   } fa_state_t;

   typedef logic [15:0] half_t;

   localparam logic [1:0] RVC_OPC_FULL = 2'b11;

   // Any opcode quadrant other than 2'b11 marks a 16-bit compressed instruction.
   function automatic logic is_rvc(input half_t h);
      return h[1:0] != RVC_OPC_FULL;
   endfunction

endpackage

// File: rtl/fetch_hsel.sv
// Halfword select and instruction assembly for fetch_align: picks the halfword at the
// cursor and builds the outgoing instruction from the read word and the buffered half.
module fetch_hsel
   import fetch_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [15:0] i_hbuf,
   input  logic        i_pc1,
   input  logic        i_hbuf_valid,
   output logic [15:0] o_half,
   output logic [31:0] o_instr,
   output logic        o_is_rvc
);

   assign o_half = i_pc1 ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_is_rvc = 1'b0;
      o_instr  = i_rdata;
      // A buffered low half always completes a 32-bit instruction with the next word's low half.
      if (i_hbuf_valid) begin
         o_instr = {i_rdata[15:0], i_hbuf};
      end else if (is_rvc(o_half)) begin
         o_is_rvc = 1'b1;
         o_instr  = {16'h0000, o_half};
      end
   end

endmodule

// File: rtl/fetch_align.sv
// RV32IC fetch and realignment stage: drives the instruction-memory word address and
// presents one instruction per cycle to decode. Define FETCH_ALIGN_RVC_EN for compressed support.
module fetch_align
   import fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 11,
   parameter int          DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  stall,
   output logic                  instr_valid,
   output logic [31:0]           instr,
   output logic [31:0]           instr_pc,
   output logic                  instr_is_rvc
);

`ifdef FETCH_ALIGN_RVC_EN
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
   localparam logic [31:0]           PC_RST = RESET_PC & PC_MASK;
   localparam logic [ADDR_WIDTH-1:0] WA_RST = RESET_PC[ADDR_WIDTH+1:2];
   localparam logic [ADDR_WIDTH-1:0] WA_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   fa_state_t             r_state;
   fa_state_t             w_state_nxt;
   logic [31:0]           r_pc;
   logic [31:0]           w_pc_nxt;
   logic [ADDR_WIDTH-1:0] r_wa;
   logic [ADDR_WIDTH-1:0] w_wa_nxt;
   logic                  w_emit;
   logic                  w_step4;
   logic                  w_wa_inc;
   logic [31:0]           w_instr;
   logic                  w_is_rvc;

`ifdef FETCH_ALIGN_RVC_EN
   logic [15:0] r_hbuf;
   logic        r_hbuf_valid;
   logic [15:0] w_half;
   logic        w_bubble;

   fetch_hsel u_hsel (
      .i_rdata      (imem_rdata),
      .i_hbuf       (r_hbuf),
      .i_pc1        (r_pc[1]),
      .i_hbuf_valid (r_hbuf_valid),
      .o_half       (w_half),
      .o_instr      (w_instr),
      .o_is_rvc     (w_is_rvc)
   );
`else
   assign w_instr  = imem_rdata;
   assign w_is_rvc = 1'b0;
`endif

   // Classify what the current read word offers: an instruction, or a straddle bubble.
   always_comb begin
      w_emit   = 1'b0;
      w_step4  = 1'b1;
      w_wa_inc = 1'b0;
`ifdef FETCH_ALIGN_RVC_EN
      w_bubble = 1'b0;
`endif
      if (r_state == FA_RUN) begin
`ifdef FETCH_ALIGN_RVC_EN
         if (r_hbuf_valid) begin
            w_emit = 1'b1;
         end else if (w_is_rvc) begin
            w_emit   = 1'b1;
            w_step4  = 1'b0;
            w_wa_inc = r_pc[1];
         end else if (!r_pc[1]) begin
            w_emit   = 1'b1;
            w_wa_inc = 1'b1;
         end else begin
            w_bubble = 1'b1;
            w_wa_inc = 1'b1;
         end
`else
         w_emit   = 1'b1;
         w_wa_inc = 1'b1;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_wa_nxt    = r_wa;
      if (r_state == FA_FILL) begin
         w_state_nxt = FA_RUN;
      end
      // Redirect wins over stall so a taken branch is never lost behind a decode stall.
      if (redirect_valid) begin
         w_state_nxt = FA_RUN;
         w_pc_nxt    = redirect_pc & PC_MASK;
         w_wa_nxt    = redirect_pc[ADDR_WIDTH+1:2];
      end else if (!stall) begin
         if (w_emit) begin
            w_pc_nxt = r_pc + (w_step4 ? 32'd4 : 32'd2);
         end
         if (w_wa_inc) begin
            w_wa_nxt = r_wa + WA_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FA_FILL;
         r_pc    <= PC_RST;
         r_wa    <= WA_RST;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_wa    <= w_wa_nxt;
      end
   end

`ifdef FETCH_ALIGN_RVC_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hbuf       <= 16'h0000;
         r_hbuf_valid <= 1'b0;
      end else if (redirect_valid) begin
         r_hbuf_valid <= 1'b0;
      end else if (!stall) begin
         if (w_bubble) begin
            r_hbuf       <= w_half;
            r_hbuf_valid <= 1'b1;
         end else if (w_emit) begin
            r_hbuf_valid <= 1'b0;
         end
      end
   end
`endif

   // Address is combinational so the memory's registered data lines up with r_wa next cycle.
   assign imem_addr    = w_wa_nxt;
   assign instr_valid  = w_emit;
   assign instr        = w_emit ? w_instr : 32'h0;
   assign instr_is_rvc = w_emit & w_is_rvc;
   assign instr_pc     = r_pc;

endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction fetch and realignment stage for the RV32IC core. It sits directly upstream of the instruction memory: it drives the memory's word address and consumes the memory's registered read data. It extracts 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle a word boundary, and presents one instruction per cycle with its PC to decode.

## Interface
- ADDR_WIDTH, 11, instruction-memory word-address width.
- DATA_WIDTH, 32, memory word width. Only 32 is supported.
- RESET_PC, 32'h0, byte PC after reset. Must be halfword-aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_WIDTH  word address for the memory. Combinational (next word address).
- imem_rdata  in  32  memory read data. Valid one clock after imem_addr is sampled.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  32  redirect target. Bit 0 is ignored.
- stall  in  1  decode not ready.
- instr_valid  out  1  instr, instr_pc and instr_is_rvc are valid.
- instr  out  32  instruction. For compressed instructions, [31:16]=0.
- instr_pc  out  32  byte PC of instr.
- instr_is_rvc  out  1  instr is a 16-bit compressed instruction.

## Operation
- State: FA_FILL, FA_RUN. Registers:
  - pc: byte PC of the next instruction.
  - wa_q: word address whose data is in imem_rdata.
  - hbuf[15:0]: buffered low half of a straddling instruction.
  - hbuf_valid.
- imem_addr = wa_next; wa_q <= wa_next. Invariant in FA_RUN: imem_rdata == RAM[wa_q].
- FA_FILL (after reset only): instr_valid=0, wa_next=wa_q. Goes to FA_RUN after 1 cycle.
- Halfword at the cursor: h = pc[1] ? imem_rdata[31:16] : imem_rdata[15:0]. An instruction is compressed when h[1:0] != 2'b11.
- FA_RUN cases:
  - hbuf_valid=0, pc[1]=0, compressed: emit h, pc+=2, hold wa.
  - hbuf_valid=0, pc[1]=0, 32-bit: emit imem_rdata, pc+=4, wa+1.
  - hbuf_valid=0, pc[1]=1, compressed: emit h, pc+=2, wa+1.
  - hbuf_valid=0, pc[1]=1, 32-bit: hbuf<=h, hbuf_valid<=1, wa+1, instr_valid=0 (bubble). pc is unchanged.
  - hbuf_valid=1: emit {imem_rdata[15:0], hbuf}, instr_pc=pc, pc+=4, hbuf_valid<=0, hold wa.
- An instruction is consumed on a rising edge with instr_valid & ~stall. State only advances on consumption or on a bubble edge.
- stall=1: all registers hold, wa_next=wa_q. Outputs stay stable because imem_rdata is re-read from the same address.
- redirect_valid=1 (any state, overrides stall):
  - pc<=redirect_pc & ~1.
  - wa_next=redirect_pc[ADDR_WIDTH+1:2].
  - hbuf_valid<=0, state<=FA_RUN.
  - The instruction currently presented is discarded.
- instr_valid=0 ⇒ instr=0, instr_is_rvc=0, instr_pc=pc.
- Arithmetic:
  - pc wraps modulo 2^32.
  - Word address = pc[ADDR_WIDTH+1:2] and wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values:
  - state=FA_FILL, pc=RESET_PC, wa_q=RESET_PC[ADDR_WIDTH+1:2], hbuf=0, hbuf_valid=0.
  - instr_valid=0, instr=0, instr_is_rvc=0, instr_pc=RESET_PC.
  - imem_addr=RESET_PC[ADDR_WIDTH+1:2].
- First instruction: valid 2 cycles after reset deassertion (the FA_FILL cycle, then valid).
- Redirect asserted in cycle t: target instruction is valid in cycle t+1. It is valid in t+2 if the target is a straddling 32-bit instruction.
- Throughput: 1 instruction/cycle, minus one bubble per straddling 32-bit instruction.
- Reset asserted mid-operation: immediate return to reset values; any buffered halfword is lost.

## Configuration
- FETCH_ALIGN_RVC_EN defined: full compressed support as above.
- Undefined:
  - Every word is treated as a 32-bit instruction; pc+=4.
  - redirect_pc[1:0] is ignored.
  - instr_is_rvc=0; hbuf/hbuf_valid logic is absent.

## Structure
- Package fetch_pkg contains:
  - fa_state_t enum (FA_FILL, FA_RUN).
  - half_t typedef (logic [15:0]).
  - RVC_OPC_FULL = 2'b11 constant.
  - is_rvc(half_t) function.
- One sub-module, fetch_hsel: combinational halfword select and instruction assembly from imem_rdata, hbuf, pc[1] and hbuf_valid.
- The state machine and registers stay in fetch_align.

## Test plan
- Reset release, RAM[0]=32'h00A00093 → FA_FILL cycle with instr_valid=0, then instr=32'h00A00093, instr_pc=0, imem_addr=1.
- RAM[1]=32'h45014081 → two consecutive outputs:
  - instr=32'h00004081, pc=4, rvc=1, imem_addr held at 1.
  - instr=32'h00004501, pc=6, then imem_addr=2.
- Straddle: RAM[2]=32'h00934081, RAM[3]=32'h123400A0 →
  - 32'h00004081 at pc=8.
  - One bubble.
  - 32'h00A00093 at pc=0xA, rvc=0.
  - 32'h00001234 at pc=0xE.
- stall=1 for 3 cycles while valid → instr, instr_pc and imem_addr unchanged. Release → next instruction on the following cycle.
- Redirect to 0x20 during a bubble (hbuf_valid=1), with stall=1 asserted at the same time → hbuf_valid cleared; next cycle instr=RAM[8], instr_pc=0x20.
- Redirect to 32'h1FFC with RAM[2047] a 32-bit instruction → instr_pc=0x1FFC, then imem_addr wraps to 0, pc=0x2000.
